// File: rtl/vga_scan_gen_if.sv
// Pixel-side bundle of the raster scan generator. The renderer uses the
// coordinates and colour inputs, and the VGA connector uses the pin outputs.
interface vga_scan_gen_if;
    logic [3:0]  r_in;
    logic [3:0]  g_in;
    logic [3:0]  b_in;
    logic [10:0] draw_x;
    logic [9:0]  draw_y;
    logic        hsync;
    logic        vsync;
    logic [3:0]  r_out;
    logic [3:0]  g_out;
    logic [3:0]  b_out;
    logic        active;
    logic        frame_tick;

    modport master (
        input  r_in, g_in, b_in,
        output draw_x, draw_y, hsync, vsync,
        output r_out, g_out, b_out, active, frame_tick
    );

    modport slave (
        output r_in, g_in, b_in,
        input  draw_x, draw_y, hsync, vsync,
        input  r_out, g_out, b_out, active, frame_tick
    );
endinterface

// File: rtl/vga_scan_gen.sv
// Raster scan generator. It produces the draw coordinates, delays the timing
// flags to match the renderer latency, and drives blanked RGB and the syncs.
module vga_scan_gen #(
    parameter int unsigned H_ACTIVE = 1440,
    parameter int unsigned H_FP     = 80,
    parameter int unsigned H_SYNC   = 152,
    parameter int unsigned H_BP     = 232,
    parameter int unsigned V_ACTIVE = 900,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 25,
    parameter int unsigned H_POL    = 0,
    parameter int unsigned V_POL    = 1,
    parameter int unsigned PIPE_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    vga_scan_gen_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] LP_H_MAX    = 11'(H_TOTAL - 1);
    localparam logic [10:0] LP_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] LP_HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] LP_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  LP_V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  LP_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  LP_V_LASTA  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  LP_VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  LP_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic        LP_HS_ON    = (H_POL != 0);
    localparam logic        LP_VS_ON    = (V_POL != 0);

    logic [10:0]         r_x;
    logic [9:0]          r_y;
    logic                w_x_wrap;
    logic                w_y_wrap;
    logic                w_act_raw;
    logic                w_hs_raw;
    logic                w_vs_raw;
    logic [PIPE_LAT-1:0] r_act_sr;
    logic [PIPE_LAT-1:0] r_hs_sr;
    logic [PIPE_LAT-1:0] r_vs_sr;
    logic [3:0]          r_r;
    logic [3:0]          r_g;
    logic [3:0]          r_b;
    logic                r_active;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_tick;

    always_comb begin
        w_x_wrap  = (r_x == LP_H_MAX);
        w_y_wrap  = (r_y == LP_V_MAX);
        w_act_raw = (r_x < LP_H_ACT) && (r_y < LP_V_ACT);
        w_hs_raw  = (r_x >= LP_HS_BEG) && (r_x <= LP_HS_END);
        w_vs_raw  = (r_y >= LP_VS_BEG) && (r_y <= LP_VS_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_act_sr <= '0;
            r_hs_sr  <= '0;
            r_vs_sr  <= '0;
            r_r      <= '0;
            r_g      <= '0;
            r_b      <= '0;
            r_active <= 1'b0;
            r_hsync  <= ~LP_HS_ON;
            r_vsync  <= ~LP_VS_ON;
            r_tick   <= 1'b0;
        end else begin
            r_x <= w_x_wrap ? '0 : r_x + 11'd1;
            if (w_x_wrap) begin
                r_y <= w_y_wrap ? '0 : r_y + 10'd1;
            end

            r_act_sr[0] <= w_act_raw;
            r_hs_sr[0]  <= w_hs_raw;
            r_vs_sr[0]  <= w_vs_raw;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                r_act_sr[i] <= r_act_sr[i-1];
                r_hs_sr[i]  <= r_hs_sr[i-1];
                r_vs_sr[i]  <= r_vs_sr[i-1];
            end

            // The tap lines up with the colour the renderer returns for the same coordinate.
            r_active <= r_act_sr[PIPE_LAT-1];
            r_r      <= r_act_sr[PIPE_LAT-1] ? bus.r_in : '0;
            r_g      <= r_act_sr[PIPE_LAT-1] ? bus.g_in : '0;
            r_b      <= r_act_sr[PIPE_LAT-1] ? bus.b_in : '0;
            r_hsync  <= r_hs_sr[PIPE_LAT-1] ? LP_HS_ON : ~LP_HS_ON;
            r_vsync  <= r_vs_sr[PIPE_LAT-1] ? LP_VS_ON : ~LP_VS_ON;

            // The tick is set one cycle early so that it is high while (0, V_ACTIVE) is presented.
            r_tick   <= w_x_wrap && (r_y == LP_V_LASTA);
        end
    end

    assign bus.draw_x     = r_x;
    assign bus.draw_y     = r_y;
    assign bus.r_out      = r_r;
    assign bus.g_out      = r_g;
    assign bus.b_out      = r_b;
    assign bus.active     = r_active;
    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen. It has one default-timing instance and two reduced-timing
// instances (latency 1 and 3, the second one with inverted polarities).
module tb_vga_scan_gen;
    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int hpol; int vpol; int lat;
    } tcfg_t;

    localparam tcfg_t CFG_A = '{ha:1440, hf:80, hs:152, hb:232, va:900, vf:3, vs:6, vb:25,
                                hpol:0, vpol:1, lat:1};
    localparam tcfg_t CFG_B = '{ha:20, hf:3, hs:5, hb:4, va:6, vf:2, vs:2, vb:2,
                                hpol:0, vpol:1, lat:1};
    localparam tcfg_t CFG_C = '{ha:20, hf:3, hs:5, hb:4, va:6, vf:2, vs:2, vb:2,
                                hpol:1, vpol:0, lat:3};

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   n;
    bit   did_pulse;

    vga_scan_gen_if if_a ();
    vga_scan_gen_if if_b ();
    vga_scan_gen_if if_c ();

    vga_scan_gen #(
        .H_ACTIVE(CFG_A.ha), .H_FP(CFG_A.hf), .H_SYNC(CFG_A.hs), .H_BP(CFG_A.hb),
        .V_ACTIVE(CFG_A.va), .V_FP(CFG_A.vf), .V_SYNC(CFG_A.vs), .V_BP(CFG_A.vb),
        .H_POL(CFG_A.hpol), .V_POL(CFG_A.vpol), .PIPE_LAT(CFG_A.lat)
    ) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));

    vga_scan_gen #(
        .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hf), .H_SYNC(CFG_B.hs), .H_BP(CFG_B.hb),
        .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vf), .V_SYNC(CFG_B.vs), .V_BP(CFG_B.vb),
        .H_POL(CFG_B.hpol), .V_POL(CFG_B.vpol), .PIPE_LAT(CFG_B.lat)
    ) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

    vga_scan_gen #(
        .H_ACTIVE(CFG_C.ha), .H_FP(CFG_C.hf), .H_SYNC(CFG_C.hs), .H_BP(CFG_C.hb),
        .V_ACTIVE(CFG_C.va), .V_FP(CFG_C.vf), .V_SYNC(CFG_C.vs), .V_BP(CFG_C.vb),
        .H_POL(CFG_C.hpol), .V_POL(CFG_C.vpol), .PIPE_LAT(CFG_C.lat)
    ) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // The renderer returns the low nibble of the x coordinate issued lat cycles earlier.
    // Before that coordinate exists, it returns 4'hA, which must never reach the pins.
    function automatic logic [3:0] rin_val(input tcfg_t c, input int cyc);
        int ht;
        ht = c.ha + c.hf + c.hs + c.hb;
        if (cyc - c.lat < 0) return 4'hA;
        return 4'((cyc - c.lat) % ht);
    endfunction

    // Expected outputs n cycles after the last reset edge, derived from the frame geometry.
    task automatic check_dut(input string tag, input tcfg_t c, input int cyc,
                             input logic [10:0] dx, input logic [9:0] dy,
                             input logic hs, input logic vs,
                             input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                             input logic act, input logic tick);
        int ht, vt, ex, ey, m, xm, ym;
        bit e_act, e_hs, e_vs;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        ex = cyc % ht;
        ey = (cyc / ht) % vt;
        m  = cyc - c.lat - 1;
        e_act = 1'b0; e_hs = 1'b0; e_vs = 1'b0; xm = 0;
        if (m >= 0) begin
            xm = m % ht;
            ym = (m / ht) % vt;
            e_act = (xm < c.ha) && (ym < c.va);
            e_hs  = (xm >= c.ha + c.hf) && (xm < c.ha + c.hf + c.hs);
            e_vs  = (ym >= c.va + c.vf) && (ym < c.va + c.vf + c.vs);
        end
        check({tag, ".draw_x"}, int'(dx), ex);
        check({tag, ".draw_y"}, int'(dy), ey);
        check({tag, ".active"}, int'(act), int'(e_act));
        check({tag, ".r_out"}, int'(r), e_act ? (xm % 16) : 0);
        check({tag, ".g_out"}, int'(g), e_act ? 15 : 0);
        check({tag, ".b_out"}, int'(b), e_act ? 15 : 0);
        check({tag, ".hsync"}, int'(hs), e_hs ? c.hpol : 1 - c.hpol);
        check({tag, ".vsync"}, int'(vs), e_vs ? c.vpol : 1 - c.vpol);
        check({tag, ".frame_tick"}, int'(tick), (ex == 0 && ey == c.va) ? 1 : 0);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        n         = 0;
        did_pulse = 1'b0;
        rst       = 1'b1;
        if_a.r_in = 4'h0; if_a.g_in = 4'hF; if_a.b_in = 4'hF;
        if_b.r_in = 4'h0; if_b.g_in = 4'hF; if_b.b_in = 4'hF;
        if_c.r_in = 4'h0; if_c.g_in = 4'hF; if_c.b_in = 4'hF;

        for (int g = 0; g < 8000; g++) begin
            @(posedge clk);
            n = rst ? 0 : n + 1;
            @(negedge clk);

            check_dut("A", CFG_A, n, if_a.draw_x, if_a.draw_y, if_a.hsync, if_a.vsync,
                      if_a.r_out, if_a.g_out, if_a.b_out, if_a.active, if_a.frame_tick);
            check_dut("B", CFG_B, n, if_b.draw_x, if_b.draw_y, if_b.hsync, if_b.vsync,
                      if_b.r_out, if_b.g_out, if_b.b_out, if_b.active, if_b.frame_tick);
            check_dut("C", CFG_C, n, if_c.draw_x, if_c.draw_y, if_c.hsync, if_c.vsync,
                      if_c.r_out, if_c.g_out, if_c.b_out, if_c.active, if_c.frame_tick);

            // Hand-computed points at the default timing with latency 1.
            if (n == 1)    check("A.act_pre", int'(if_a.active), 0);
            if (n == 2)    check("A.act_first", int'(if_a.active), 1);
            if (n == 1441) check("A.act_last", int'(if_a.active), 1);
            if (n == 1442) check("A.act_end", int'(if_a.active), 0);
            if (n == 1521) check("A.hs_pre", int'(if_a.hsync), 1);
            if (n == 1522) check("A.hs_fall", int'(if_a.hsync), 0);
            if (n == 1673) check("A.hs_last", int'(if_a.hsync), 0);
            if (n == 1674) check("A.hs_rise", int'(if_a.hsync), 1);
            if (n == 1903) check("A.x_max", int'(if_a.draw_x), 1903);
            if (n == 1904) check("A.x_wrap", int'(if_a.draw_x), 0);
            if (n == 1904) check("A.y_step", int'(if_a.draw_y), 1);
            if (n == 2604 && !did_pulse) begin
                check("A.x_at_rst", int'(if_a.draw_x), 700);
                check("A.y_at_rst", int'(if_a.draw_y), 1);
            end
            if (n == 0 && did_pulse) begin
                check("A.rst_x", int'(if_a.draw_x), 0);
                check("A.rst_rgb", int'({if_a.r_out, if_a.g_out, if_a.b_out}), 0);
                check("A.rst_hs", int'(if_a.hsync), 1);
                check("A.rst_vs", int'(if_a.vsync), 0);
            end

            // Hand-computed points at the reduced timing (line 32, frame 384).
            if (n == 191) check("B.tick_pre", int'(if_b.frame_tick), 0);
            if (n == 192) check("B.tick", int'(if_b.frame_tick), 1);
            if (n == 576) check("B.tick_2", int'(if_b.frame_tick), 1);
            if (n == 257) check("B.vs_pre", int'(if_b.vsync), 0);
            if (n == 258) check("B.vs_rise", int'(if_b.vsync), 1);
            if (n == 321) check("B.vs_last", int'(if_b.vsync), 1);
            if (n == 322) check("B.vs_fall", int'(if_b.vsync), 0);
            if (n == 384) check("B.y_wrap", int'(if_b.draw_y), 0);
            if (n == 3)   check("C.blank_lat", int'(if_c.g_out), 0);
            if (n == 9)   check("C.r_lat", int'(if_c.r_out), 5);
            if (n == 23)  check("C.g_last", int'(if_c.g_out), 15);
            if (n == 24)  check("C.g_blank", int'(if_c.g_out), 0);
            if (n == 26)  check("C.hs_pre", int'(if_c.hsync), 0);
            if (n == 27)  check("C.hs_on", int'(if_c.hsync), 1);
            if (n == 32)  check("C.hs_off", int'(if_c.hsync), 0);

            if (g == 2) begin
                rst = 1'b0;
            end else if (rst && did_pulse) begin
                rst = 1'b0;
            end else if (!rst && !did_pulse && n == 2604) begin
                rst       = 1'b1;
                did_pulse = 1'b1;
            end
            if_a.r_in = rin_val(CFG_A, n);
            if_b.r_in = rin_val(CFG_B, n);
            if_c.r_in = rin_val(CFG_C, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Raster scan generator for the 1440x900 @ 60 Hz display path. It produces the `draw_x`/`draw_y` pixel coordinates that the pixel renderer consumes, and takes back the renderer's 4-bit RGB after a fixed pipeline latency. It emits the latency-aligned `hsync`/`vsync` and blanked RGB to the VGA pins, plus a once-per-frame tick for game-state update logic.

## Interface
- `H_ACTIVE`, 1440, visible pixels per line
- `H_FP`, 80, horizontal front porch (pixels)
- `H_SYNC`, 152, hsync width (pixels)
- `H_BP`, 232, horizontal back porch (pixels)
- `V_ACTIVE`, 900, visible lines
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vsync width (lines)
- `V_BP`, 25, vertical back porch (lines)
- `H_POL`, 0, hsync active level (0 = active-low)
- `V_POL`, 1, vsync active level (1 = active-high)
- `PIPE_LAT`, 1, renderer latency in cycles, from coordinate out to RGB in (range 1..4)

Ports:
- `clk`  in  1  pixel clock, 106.5 MHz; one clock domain only
- `rst`  in  1  synchronous, active-high reset
- `r_in`, `g_in`, `b_in`  in  4 each  renderer colour for the coordinate issued `PIPE_LAT` cycles earlier
- `draw_x`  out  11  horizontal counter, 0..H_TOTAL-1
- `draw_y`  out  10  vertical counter, 0..V_TOTAL-1
- `hsync`, `vsync`  out  1 each  to VGA connector
- `r_out`, `g_out`, `b_out`  out  4 each  to VGA DAC
- `active`  out  1  aligned with `r_out`; high while a visible pixel is being driven
- `frame_tick`  out  1  one-cycle pulse at start of vertical blanking

## Operation
- `H_TOTAL` = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP` = 1904. `V_TOTAL` = 934. Both are derived localparams.
- `draw_x` is registered and increments every cycle, wrapping from `H_TOTAL`-1 to 0. `draw_y` increments on that wrap and wraps from `V_TOTAL`-1 to 0 when both counters are at their maximum.
- Undelayed raw signals are computed from the counters:
  - `act_raw` = (`draw_x` < `H_ACTIVE`) and (`draw_y` < `V_ACTIVE`)
  - `hs_raw` asserted for `draw_x` in [`H_ACTIVE`+`H_FP`, `H_ACTIVE`+`H_FP`+`H_SYNC`-1] = [1520, 1671]
  - `vs_raw` asserted for `draw_y` in [903, 908], across the whole line
- `act_raw`, `hs_raw` and `vs_raw` pass through a `PIPE_LAT`-deep shift register. At the tap, RGB is registered:
  - RGB out = `r_in`/`g_in`/`b_in` when the delayed active bit is 1
  - RGB out = 0 otherwise
  - `hsync`, `vsync` and `active` are registered in the same stage.
- Sync outputs = raw value XNOR polarity: asserted level = `H_POL`/`V_POL`, inactive level = inverse.
- `frame_tick` is registered and undelayed. It is 1 for exactly the cycle where `draw_x`=0 and `draw_y`=`V_ACTIVE`.
- Blanking is enforced here. The renderer may output a non-zero colour anywhere; off-screen pixels are never driven.

## Timing
- Reset values:
  - `draw_x`=0, `draw_y`=0
  - `r_out`/`g_out`/`b_out`=0, `active`=0, `frame_tick`=0
  - `hsync`=1, `vsync`=0 (inactive levels for default polarities)
  - delay-line stages cleared to inactive
- First cycle after `rst` deasserts: `draw_x`=0, `draw_y`=0.
- Coordinate-to-pin latency is `PIPE_LAT`+1 cycles. The colour and sync for the coordinate presented at cycle t appear on the pins at t+`PIPE_LAT`+1.
- Line = 1904 cycles. Frame = 1,778,336 cycles. hsync pulse = 152 cycles. vsync pulse = 6 lines = 11,424 cycles.
- Reset asserted mid-frame: in the next cycle the counters are 0 and every output is at its reset value. No `frame_tick` is issued for the aborted frame. Outputs stay blank for `PIPE_LAT`+1 cycles after release.
- Counter wrap in x and y in the same cycle: `draw_y` goes to 0, never to `V_TOTAL`.

## Test plan
- **Counting:** release reset, run 1904 cycles -> `draw_x` runs 0..1903 then returns to 0; `draw_y` steps 0->1 on that same cycle. After 1,778,336 cycles both counters are 0.
- **hsync:** default parameters -> `hsync` goes low exactly `PIPE_LAT`+1 cycles after `draw_x`=1520, stays low for 152 cycles, and does so once per line.
- **vsync and frame_tick:**
  - `vsync` rises `PIPE_LAT`+1 cycles after (`draw_x`=0, `draw_y`=903) and stays high 11,424 cycles.
  - `frame_tick` pulses once per 1,778,336 cycles, at (0, 900).
- **Blanking:** hold `r_in`=`g_in`=`b_in`=4'hF -> the outputs are F for exactly 1440 consecutive cycles per line, starting `PIPE_LAT`+1 cycles after `draw_x`=0, on lines 0..899 only; 0 everywhere else. `active` matches.
- **Latency:** drive `r_in` = `draw_x`[3:0] delayed by `PIPE_LAT`, for `PIPE_LAT`=1 and `PIPE_LAT`=3 -> `r_out` at the pin equals the low nibble of the pixel index within the line.
- **Mid-frame reset:** assert `rst` for 1 cycle at `draw_x`=700, `draw_y`=400 -> next cycle counters are 0, RGB is 0, `hsync`=1, `vsync`=0, and no `frame_tick` occurs until (0, 900) of the new frame.
